ips_line_follower: RTL and testbench

IPS_LINE_FOLLOWER -- requirements
Module: ips_line_follower

---
 rtl/ips_pkg.sv | 36 +++
 rtl/ips_debounce.sv | 41 ++++
 rtl/ips_line_follower.sv | 108 ++++++++++
 tb/tb_ips_line_follower.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ips_pkg.sv
// ips_pkg: shared definitions for the line follower.
//   state_t   - controller state encoding (visible on state_o)
//   IN_*      - H-bridge direction codes driven on IN
//   drive_code- maps a state and remembered turn direction to an IN code
package ips_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FWD    = 3'd1,
        ST_LEFT   = 3'd2,
        ST_RIGHT  = 3'd3,
        ST_SEARCH = 3'd4,
        ST_STOP   = 3'd5
    } state_t;

    localparam logic [3:0] IN_FWD   = 4'b1001;
    localparam logic [3:0] IN_LEFT  = 4'b1010;
    localparam logic [3:0] IN_RIGHT = 4'b0101;
    localparam logic [3:0] IN_OFF   = 4'b0000;

    // dir_right: 0 = last turn was LEFT, 1 = last turn was RIGHT.
    // SEARCH keeps turning the way the line was last seen.
    function automatic logic [3:0] drive_code(state_t s, logic dir_right);
        logic [3:0] code;
        code = IN_OFF;
        case (s)
            ST_FWD:    code = IN_FWD;
            ST_LEFT:   code = IN_LEFT;
            ST_RIGHT:  code = IN_RIGHT;
            ST_SEARCH: code = dir_right ? IN_RIGHT : IN_LEFT;
            default:   code = IN_OFF;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/ips_debounce.sv
// ips_debounce: one sensor bit, 2-flop synchroniser followed by a
// stability counter.
//   clk, rst - system clock, async active-high reset
//   raw      - asynchronous sensor level
//   filt     - debounced level; follows the synchronised level once it
//              has differed from filt for DEB_CYC consecutive cycles
module ips_debounce #(
    parameter int DEB_CYC = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filt
);

    localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            filt <= 1'b0;
            cnt  <= '0;
        end else begin
            sync <= {sync[0], raw};
            // Agreement with filt means no pending change; any bounce back
            // restarts the count from zero.
            if (sync[1] == filt) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYC - 1)) begin
                filt <= sync[1];
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ips_line_follower.sv
// ips_line_follower: line-following motor controller.
//   clk, rst  - system clock, async active-high reset
//   IPS       - raw sensor bits, bit 0 leftmost
//   run       - drive enable; low returns to IDLE
//   duty_fwd  - PWM duty used in FWD
//   duty_turn - PWM duty used in LEFT/RIGHT/SEARCH
//   IN        - registered H-bridge direction code
//   EN        - registered motor enables (both bits identical)
//   state_o   - current state encoding
//   lost      - high while in STOP (line lost too long)
module ips_line_follower
    import ips_pkg::*;
#(
    parameter int N_IPS   = 3,
    parameter int DEB_CYC = 1000,
    parameter int PWM_W   = 8,
    parameter int LOST_TO = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IPS-1:0] IPS,
    input  logic             run,
    input  logic [PWM_W-1:0] duty_fwd,
    input  logic [PWM_W-1:0] duty_turn,
    output logic [3:0]       IN,
    output logic [1:0]       EN,
    output logic [2:0]       state_o,
    output logic             lost
);

    localparam int C  = (N_IPS - 1) / 2;
    localparam int LW = $clog2(LOST_TO);

    logic [N_IPS-1:0] filt;
    state_t           state_q, state_nxt, decide;
    logic             dir_q, dir_nxt;      // 1 = last turn RIGHT
    logic [LW-1:0]    lost_cnt;
    logic [PWM_W-1:0] cnt, duty_latched;
    logic             drive_off;

    genvar g;
    generate
        for (g = 0; g < N_IPS; g++) begin : g_deb
            ips_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
                .clk  (clk),
                .rst  (rst),
                .raw  (IPS[g]),
                .filt (filt[g])
            );
        end
    endgenerate

    // Centre wins, then any left-side bit, then any right-side bit.
    always_comb begin
        decide = ST_SEARCH;
        if (filt[C])                    decide = ST_FWD;
        else if (|filt[C-1:0])          decide = ST_LEFT;
        else if (|filt[N_IPS-1:C+1])    decide = ST_RIGHT;
    end

    always_comb begin
        state_nxt = state_q;
        dir_nxt   = dir_q;
        if (!run) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state_q)
                ST_STOP:   state_nxt = ST_STOP;
                ST_SEARCH: state_nxt = (lost_cnt == LW'(LOST_TO - 1)) ? ST_STOP : decide;
                default:   state_nxt = decide;
            endcase
        end
        if (state_nxt == ST_LEFT)  dir_nxt = 1'b0;
        if (state_nxt == ST_RIGHT) dir_nxt = 1'b1;
    end

    // Motors are cut on the same edge that enters IDLE/STOP, not at wrap.
    assign drive_off = (state_nxt == ST_IDLE) || (state_nxt == ST_STOP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            dir_q        <= 1'b0;
            lost_cnt     <= '0;
            IN           <= IN_OFF;
            cnt          <= '0;
            duty_latched <= '0;
            EN           <= 2'b00;
        end else begin
            state_q  <= state_nxt;
            dir_q    <= dir_nxt;
            lost_cnt <= (state_q == ST_SEARCH) ? lost_cnt + 1'b1 : '0;
            IN       <= drive_code(state_nxt, dir_nxt);
            cnt      <= cnt + 1'b1;
            // Duty only changes at the period boundary so a period is never
            // truncated or stretched by a mid-period duty update.
            if (drive_off)
                duty_latched <= '0;
            else if (&cnt)
                duty_latched <= (state_nxt == ST_FWD) ? duty_fwd : duty_turn;
            EN <= drive_off ? 2'b00 : {2{cnt < duty_latched}};
        end
    end

    assign state_o = state_q;
    assign lost    = (state_q == ST_STOP);

endmodule

// File: tb/tb_ips_line_follower.sv
module tb_ips_line_follower;

    localparam logic [2:0] S_IDLE = 3'd0, S_FWD = 3'd1, S_LEFT = 3'd2,
                           S_RIGHT = 3'd3, S_SEARCH = 3'd4, S_STOP = 3'd5;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] IPS;
    logic       run;
    logic [3:0] duty_fwd, duty_turn;
    logic [3:0] IN;
    logic [1:0] EN;
    logic [2:0] state_o;
    logic       lost;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [2:0] st; logic [3:0] in; } exp_t;
    exp_t exp_q[$];
    logic en_q[$];

    ips_line_follower #(.N_IPS(5), .DEB_CYC(4), .PWM_W(4), .LOST_TO(20)) dut (
        .clk(clk), .rst(rst), .IPS(IPS), .run(run),
        .duty_fwd(duty_fwd), .duty_turn(duty_turn),
        .IN(IN), .EN(EN), .state_o(state_o), .lost(lost)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every change of {state_o, IN} must match the next
    // queued expectation.
    logic [6:0] prev = {S_IDLE, 4'b0000};
    always begin
        logic [6:0] cur;
        exp_t e;
        @(posedge clk);
        #2;
        cur = {state_o, IN};
        if (cur !== prev) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change got st=%0d IN=%b", state_o, IN);
            end else begin
                e = exp_q.pop_front();
                if (cur !== {e.st, e.in}) begin
                    errors++;
                    $display("FAIL sb_transition got st=%0d IN=%b exp st=%0d IN=%b",
                             state_o, IN, e.st, e.in);
                end
            end
            prev = cur;
        end
    end

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; IPS = '0; duty_fwd = '0; duty_turn = '0;
        repeat (3) tick();
        checks++;
        if ({state_o, IN, EN, lost} !== {S_IDLE, 4'b0000, 2'b00, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got st=%0d IN=%b EN=%b lost=%b", state_o, IN, EN, lost);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fwd_pwm();
        int hi = 0;
        duty_fwd = 4'd8; duty_turn = 4'd0;
        run = 1'b1; IPS = 5'b00100;
        exp_q.push_back('{S_SEARCH, 4'b1010});
        exp_q.push_back('{S_FWD, 4'b1001});
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 6) begin
                checks++;
                if (state_o !== S_SEARCH) begin
                    errors++;
                    $display("FAIL fwd_latency_early got st=%0d exp %0d", state_o, S_SEARCH);
                end
            end
        end
        checks++;
        if ({state_o, IN} !== {S_FWD, 4'b1001}) begin
            errors++;
            $display("FAIL fwd_edge7 got st=%0d IN=%b exp st=1 IN=1001", state_o, IN);
        end
        repeat (20) tick();
        for (int k = 0; k < 32; k++) begin
            tick();
            if (EN == 2'b11) hi++;
        end
        checks++;
        if (hi != 16) begin
            errors++;
            $display("FAIL pwm_duty8 got %0d high of 32 exp 16", hi);
        end
    endtask

    task automatic test_glitch();
        IPS = 5'b00000;
        tick();
        IPS = 5'b00100;
        repeat (12) tick();
        checks++;
        if ({state_o, IN} !== {S_FWD, 4'b1001}) begin
            errors++;
            $display("FAIL glitch_hold got st=%0d IN=%b exp st=1 IN=1001", state_o, IN);
        end
    endtask

    task automatic test_left_search_stop();
        int hi = 0;
        int nz = 0;
        IPS = 5'b00011;
        exp_q.push_back('{S_LEFT, 4'b1010});
        repeat (7) tick();
        checks++;
        if ({state_o, IN} !== {S_LEFT, 4'b1010}) begin
            errors++;
            $display("FAIL left_entry got st=%0d IN=%b exp st=2 IN=1010", state_o, IN);
        end
        repeat (20) tick();
        for (int k = 0; k < 32; k++) begin
            tick();
            if (EN != 2'b00) nz++;
        end
        checks++;
        if (nz != 0) begin
            errors++;
            $display("FAIL pwm_duty0 got %0d nonzero EN of 32 exp 0", nz);
        end
        duty_turn = 4'd15;
        repeat (17) tick();
        for (int k = 0; k < 32; k++) begin
            tick();
            if (EN == 2'b11) hi++;
        end
        checks++;
        if (hi != 30) begin
            errors++;
            $display("FAIL pwm_duty_max got %0d high of 32 exp 30", hi);
        end
        IPS = 5'b00000;
        exp_q.push_back('{S_SEARCH, 4'b1010});
        exp_q.push_back('{S_STOP, 4'b0000});
        for (int k = 1; k <= 27; k++) begin
            tick();
            if (k == 26) begin
                checks++;
                if ({state_o, IN} !== {S_SEARCH, 4'b1010}) begin
                    errors++;
                    $display("FAIL search_before_stop got st=%0d IN=%b", state_o, IN);
                end
            end
        end
        checks++;
        if ({state_o, IN, EN, lost} !== {S_STOP, 4'b0000, 2'b00, 1'b1}) begin
            errors++;
            $display("FAIL stop_entry got st=%0d IN=%b EN=%b lost=%b", state_o, IN, EN, lost);
        end
        IPS = 5'b00100;
        nz = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (EN != 2'b00) nz++;
        end
        checks++;
        if (state_o !== S_STOP || nz != 0) begin
            errors++;
            $display("FAIL stop_hold got st=%0d en_nonzero=%0d exp st=5 0", state_o, nz);
        end
        run = 1'b0;
        exp_q.push_back('{S_IDLE, 4'b0000});
        tick();
        checks++;
        if ({state_o, lost} !== {S_IDLE, 1'b0}) begin
            errors++;
            $display("FAIL stop_release got st=%0d lost=%b exp st=0 lost=0", state_o, lost);
        end
    endtask

    task automatic test_priority();
        run = 1'b1;
        exp_q.push_back('{S_FWD, 4'b1001});
        tick();
        checks++;
        if (state_o !== S_FWD) begin
            errors++;
            $display("FAIL idle_to_fwd got st=%0d exp 1", state_o);
        end
        IPS = 5'b10001;
        exp_q.push_back('{S_LEFT, 4'b1010});
        repeat (7) tick();
        checks++;
        if ({state_o, IN} !== {S_LEFT, 4'b1010}) begin
            errors++;
            $display("FAIL prio_left got st=%0d IN=%b exp st=2 IN=1010", state_o, IN);
        end
        IPS = 5'b11000;
        exp_q.push_back('{S_RIGHT, 4'b0101});
        repeat (7) tick();
        checks++;
        if ({state_o, IN} !== {S_RIGHT, 4'b0101}) begin
            errors++;
            $display("FAIL right got st=%0d IN=%b exp st=3 IN=0101", state_o, IN);
        end
        IPS = 5'b00000;
        exp_q.push_back('{S_SEARCH, 4'b0101});
        repeat (7) tick();
        checks++;
        if ({state_o, IN} !== {S_SEARCH, 4'b0101}) begin
            errors++;
            $display("FAIL search_right got st=%0d IN=%b exp st=4 IN=0101", state_o, IN);
        end
    endtask

    task automatic test_reset_mid_search();
        repeat (3) tick();
        exp_q.push_back('{S_IDLE, 4'b0000});
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({state_o, IN, EN} !== {S_IDLE, 4'b0000, 2'b00}) begin
            errors++;
            $display("FAIL async_reset got st=%0d IN=%b EN=%b", state_o, IN, EN);
        end
        tick();
        #3 rst = 1'b0;
        exp_q.push_back('{S_SEARCH, 4'b1010});
        tick();
        checks++;
        if ({state_o, IN} !== {S_SEARCH, 4'b1010}) begin
            errors++;
            $display("FAIL after_reset got st=%0d IN=%b exp st=4 IN=1010", state_o, IN);
        end
        run = 1'b0;
        exp_q.push_back('{S_IDLE, 4'b0000});
        tick();
    endtask

    task automatic test_duty_change();
        logic pe;
        logic e;
        bit   found = 0;
        IPS = 5'b00011;
        repeat (8) tick();
        duty_turn = 4'd12;
        run = 1'b1;
        exp_q.push_back('{S_LEFT, 4'b1010});
        tick();
        repeat (20) tick();
        pe = EN[0];
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            if (pe == 1'b0 && EN == 2'b11) found = 1;
            pe = EN[0];
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL en_sync_timeout got no EN rise exp one within 40 cycles");
        end else begin
            for (int k = 1; k <= 15; k++) en_q.push_back(k < 12);
            for (int k = 16; k <= 31; k++) en_q.push_back((k - 16) < 4);
            duty_turn = 4'd4;
            for (int k = 1; k <= 31; k++) begin
                tick();
                e = en_q.pop_front();
                checks++;
                if (EN !== {2{e}}) begin
                    errors++;
                    $display("FAIL duty_change k=%0d got EN=%b exp %b", k, EN, {2{e}});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fwd_pwm();
        test_glitch();
        test_left_search_stop();
        test_priority();
        test_reset_mid_search();
        test_duty_change();
        repeat (2) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending exp 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
